move_controller: RTL and testbench

//  Turn/cursor controller directly upstream of the 7x7 board/win-detector. Converts held keyboard

---
 rtl/gomoku_pkg.sv | 30 +++
 rtl/move_controller_key_edge_repeat.sv | 45 ++++
 rtl/move_controller.sv | 144 ++++++++++++++
 tb/tb_move_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gomoku_pkg.sv
// Shared encodings for the gomoku board, win detector and move controller.
package gomoku_pkg;

  // Board side; cells are addressed as BOARD_N*x + y.
  localparam int BOARD_N = 7;
  localparam int COORD_W = 3;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BLACK = 2'd1,
    CELL_WHITE = 2'd2
  } cell_e;

  typedef enum logic {
    PLAYER_BLACK = 1'b0,
    PLAYER_WHITE = 1'b1
  } player_e;

  localparam logic [1:0] WIN_NONE  = 2'd0;
  localparam logic [1:0] WIN_BLACK = 2'd1;
  localparam logic [1:0] WIN_WHITE = 2'd2;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    PLACE = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_e;

endpackage

// File: rtl/move_controller_key_edge_repeat.sv
// Rising-edge detector for a held key level with optional auto-repeat.
// An event fires on the rising edge and then every REPEAT_CYCLES cycles of
// continuous hold; releasing the key clears the repeat counter.
module key_edge_repeat #(
  parameter int REPEAT_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  input  logic repeat_en,
  output logic key_event
);

  localparam int CW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] PERIOD = CW'(REPEAT_CYCLES);

  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          rise;
  logic          repeat_hit;

  assign rise       = level & ~level_reg;
  // cnt_reg counts hold cycles since the last event (1 on the cycle after it)
  assign repeat_hit = (REPEAT_CYCLES != 0) && repeat_en && level && level_reg
                      && (cnt_reg == PERIOD);
  assign key_event  = rise | repeat_hit;

  // Track key history and the hold-time counter between events.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      level_reg <= level;
      if (!level || !repeat_en || (REPEAT_CYCLES == 0)) begin
        cnt_reg <= '0;
      end else if (rise || repeat_hit) begin
        cnt_reg <= CW'(1);
      end else if (cnt_reg != PERIOD) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/move_controller.sv
// Cursor and turn controller feeding the board / win detector.
// Keys become events, the cursor wraps on the board, a free cell produces a
// one-cycle go, the detector result is sampled one cycle after go, and a win
// or full board freezes play until reset.
module move_controller
  import gomoku_pkg::*;
#(
  parameter int BOARD_N       = 7,
  parameter int REPEAT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       enter,
  input  logic [1:0] win_state,
  output logic       go,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       color,
  output logic       reject,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       draw
);

  localparam int         CELLS  = BOARD_N * BOARD_N;
  localparam int         IDX_W  = $clog2(CELLS);
  localparam logic [2:0] MAX_C  = 3'(BOARD_N - 1);
  localparam logic [2:0] CENTER = 3'(BOARD_N / 2);

  // Key order: 0 left, 1 right, 2 up, 3 down, 4 enter.
  logic [4:0] key_level;
  logic [4:0] key_event;

  assign key_level = {enter, down, up, right, left};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_keys
      key_edge_repeat #(
        .REPEAT_CYCLES(REPEAT_CYCLES)
      ) u_key (
        .clk      (clk),
        .resetn   (resetn),
        .level    (key_level[gi]),
        .repeat_en((gi != 4) ? 1'b1 : 1'b0),
        .key_event(key_event[gi])
      );
    end
  endgenerate

  state_e           state_reg;
  logic [CELLS-1:0] occupancy_reg;
  logic [6:0]       move_count_reg;
  logic [2:0]       x_next;
  logic [2:0]       y_next;
  logic             arrow_any;
  logic [IDX_W-1:0] cell_idx;

  assign arrow_any = |key_event[3:0];
  assign cell_idx  = IDX_W'(BOARD_N * int'(x) + int'(y));

  // Wrapped cursor candidate; opposing keys in one cycle cancel on that axis.
  always_comb begin
    x_next = x;
    y_next = y;
    if (key_event[0] && !key_event[1]) begin
      x_next = (x == 3'd0) ? MAX_C : x - 3'd1;
    end else if (key_event[1] && !key_event[0]) begin
      x_next = (x == MAX_C) ? 3'd0 : x + 3'd1;
    end
    if (key_event[2] && !key_event[3]) begin
      y_next = (y == 3'd0) ? MAX_C : y - 3'd1;
    end else if (key_event[3] && !key_event[2]) begin
      y_next = (y == MAX_C) ? 3'd0 : y + 3'd1;
    end
  end

  // Turn FSM with all outputs registered; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= PLAY;
      x              <= CENTER;
      y              <= CENTER;
      color          <= PLAYER_BLACK;
      go             <= 1'b0;
      reject         <= 1'b0;
      game_over      <= 1'b0;
      winner         <= WIN_NONE;
      draw           <= 1'b0;
      move_count_reg <= '0;
      occupancy_reg  <= '0;
    end else begin
      go     <= 1'b0;
      reject <= 1'b0;
      case (state_reg)
        PLAY: begin
          if (arrow_any) begin
            // a cursor move in the same cycle wins over enter
            x <= x_next;
            y <= y_next;
          end else if (key_event[4]) begin
            if (occupancy_reg[cell_idx]) begin
              reject <= 1'b1;
            end else begin
              occupancy_reg[cell_idx] <= 1'b1;
              move_count_reg          <= move_count_reg + 7'd1;
              go                      <= 1'b1;
              state_reg               <= PLACE;
            end
          end
        end
        PLACE: begin
          // board writes the stone at the end of this cycle
          state_reg <= CHECK;
        end
        CHECK: begin
          if (win_state != WIN_NONE) begin
            winner    <= win_state;
            game_over <= 1'b1;
            state_reg <= OVER;
          end else if (move_count_reg == 7'(CELLS)) begin
            draw      <= 1'b1;
            game_over <= 1'b1;
            state_reg <= OVER;
          end else begin
            color     <= ~color;
            state_reg <= PLAY;
          end
        end
        OVER: begin
          state_reg <= OVER;
        end
        default: begin
          state_reg <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller: a game-level reference model predicts
// go/reject strobes (queued) and the cursor/turn/result outputs every cycle.
module tb_move_controller;

  localparam int N   = 7;
  localparam int RPT = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, enter = 1'b0;
  logic [1:0] win_state = 2'd0;
  logic       go, color, reject, game_over, draw;
  logic [2:0] x, y;
  logic [1:0] winner;

  move_controller #(.BOARD_N(N), .REPEAT_CYCLES(RPT)) dut (
    .clk(clk), .resetn(resetn), .left(left), .right(right), .up(up),
    .down(down), .enter(enter), .win_state(win_state), .go(go), .x(x),
    .y(y), .color(color), .reject(reject), .game_over(game_over),
    .winner(winner), .draw(draw)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_go;
    int x;
    int y;
    int color;
    int due;
  } exp_t;
  exp_t sb[$];

  // Reference model state (game level)
  int m_x, m_y, m_color, m_over, m_winner, m_draw, m_moves, m_pending;
  bit m_occ[N][N];
  int hold[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_x = N / 2; m_y = N / 2; m_color = 0; m_over = 0; m_winner = 0;
    m_draw = 0; m_moves = 0; m_pending = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m_occ[i][j] = 1'b0;
    for (int k = 0; k < 5; k++) hold[k] = 0;
  endtask

  // What happens at the clock edge given these input levels.
  task automatic step(input logic [4:0] lv, input logic [1:0] ws, input logic rn);
    bit   ev[5];
    exp_t e;
    if (!rn) begin
      m_reset();
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (lv[k]) begin
          ev[k] = (hold[k] == 0) || (k < 4 && (hold[k] % RPT) == 0);
          hold[k]++;
        end else begin
          ev[k] = 0;
          hold[k] = 0;
        end
      end
      if (m_over != 0) begin
      end else if (m_pending == 2) begin
        m_pending = 1;
      end else if (m_pending == 1) begin
        m_pending = 0;
        if (ws != 0) begin
          m_over = 1; m_winner = int'(ws);
        end else if (m_moves == N * N) begin
          m_over = 1; m_draw = 1;
        end else begin
          m_color = 1 - m_color;
        end
      end else if (ev[0] || ev[1] || ev[2] || ev[3]) begin
        if (ev[0] != ev[1]) m_x = ev[0] ? (m_x + N - 1) % N : (m_x + 1) % N;
        if (ev[2] != ev[3]) m_y = ev[2] ? (m_y + N - 1) % N : (m_y + 1) % N;
      end else if (ev[4]) begin
        e.x = m_x; e.y = m_y; e.color = m_color; e.due = cyc + 1;
        if (m_occ[m_x][m_y]) begin
          e.is_go = 0;
        end else begin
          e.is_go = 1;
          m_occ[m_x][m_y] = 1'b1;
          m_moves++;
          m_pending = 2;
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic tick(input logic l, r, u, d, e, input logic [1:0] ws, input logic rn);
    @(negedge clk);
    #1;
    left = l; right = r; up = u; down = d; enter = e; win_state = ws; resetn = rn;
    step({e, d, u, r, l}, ws, rn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 2'd0, 1'b1);
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, 0, 2'd0, 1'b0);
    idle(1);
  endtask

  // Monitor: strobes against the scoreboard, state outputs against the model.
  always @(negedge clk) begin
    exp_t e;
    if (go || reject) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe go*2+reject", int'(go) * 2 + int'(reject), 0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind go", int'(go), int'(e.is_go));
        chk("strobe_kind reject", int'(reject), int'(!e.is_go));
        chk("strobe_x", int'(x), e.x);
        chk("strobe_y", int'(y), e.y);
        chk("strobe_color", int'(color), e.color);
        chk("strobe_cycle", cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("missing_strobe is_go", 2, int'(e.is_go));
    end
    chk("x", int'(x), m_x);
    chk("y", int'(y), m_y);
    chk("color", int'(color), m_color);
    chk("game_over", int'(game_over), m_over);
    chk("winner", int'(winner), m_winner);
    chk("draw", int'(draw), m_draw);
  end

  initial begin
    logic [4:0] lv;
    m_reset();
    // 1: reset values
    do_reset();
    chk("rst_x", int'(x), 3);  chk("rst_y", int'(y), 3);
    chk("rst_color", int'(color), 0); chk("rst_go", int'(go), 0);
    chk("rst_over", int'(game_over), 0); chk("rst_winner", int'(winner), 0);
    chk("rst_draw", int'(draw), 0);
    $display("txn reset done x=%0d y=%0d", x, y);

    // 2: cursor wrap, cancel, auto-repeat
    for (int i = 0; i < 3; i++) begin tick(1, 0, 0, 0, 0, 2'd0, 1'b1); idle(1); end
    chk("left3_x", int'(x), 0);
    tick(1, 0, 0, 0, 0, 2'd0, 1'b1); idle(1);
    chk("wrap_x", int'(x), 6);
    tick(1, 1, 0, 0, 0, 2'd0, 1'b1); idle(1);
    chk("lr_cancel_x", int'(x), 6);
    for (int i = 0; i < 13; i++) tick(0, 0, 1, 0, 0, 2'd0, 1'b1);
    idle(1);
    chk("up_repeat_y", int'(y), 6);
    $display("txn cursor x=%0d y=%0d", x, y);

    // 3: placement, turn change, reject
    do_reset();
    tick(0, 0, 0, 0, 1, 2'd0, 1'b1); idle(1);
    chk("go_high", int'(go), 1); chk("go_x", int'(x), 3);
    chk("go_y", int'(y), 3); chk("go_color", int'(color), 0);
    idle(1);
    chk("go_one_cycle", int'(go), 0);
    idle(1);
    chk("color_toggled", int'(color), 1);
    tick(0, 0, 0, 0, 1, 2'd0, 1'b1); idle(1);
    chk("reject_high", int'(reject), 1); chk("reject_no_go", int'(go), 0);
    idle(1);
    chk("reject_one_cycle", int'(reject), 0); chk("reject_color", int'(color), 1);
    $display("txn place/reject color=%0d", color);

    // 4: win latched, play frozen
    tick(0, 1, 0, 0, 0, 2'd0, 1'b1); idle(1);
    tick(0, 0, 0, 0, 1, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 2'd1, 1'b1);
    chk("win_over", int'(game_over), 1); chk("win_winner", int'(winner), 1);
    tick(0, 0, 0, 1, 0, 2'd0, 1'b1); idle(1);
    tick(1, 0, 0, 0, 1, 2'd0, 1'b1); idle(1);
    chk("over_no_go", int'(go), 0); chk("over_x", int'(x), 4);
    $display("txn win winner=%0d", winner);

    // 5: fill the board -> draw
    do_reset();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        tick(0, 0, 0, 0, 1, 2'd0, 1'b1); idle(3);
        tick(0, 0, 0, 1, 0, 2'd0, 1'b1); idle(1);
      end
      tick(0, 1, 0, 0, 0, 2'd0, 1'b1); idle(1);
    end
    chk("draw_flag", int'(draw), 1); chk("draw_over", int'(game_over), 1);
    chk("draw_winner", int'(winner), 0);
    $display("txn draw draw=%0d", draw);

    // 6: reset while go is high
    do_reset();
    tick(0, 0, 0, 0, 1, 2'd0, 1'b1);
    tick(0, 0, 0, 0, 0, 2'd0, 1'b0);
    idle(1);
    chk("midrst_go", int'(go), 0); chk("midrst_color", int'(color), 0);
    tick(0, 0, 0, 0, 1, 2'd0, 1'b1); idle(1);
    chk("midrst_reaccept", int'(go), 1);
    idle(2);
    $display("txn mid-reset re-place go ok");

    // Randomized play
    do_reset();
    lv = '0;
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] ws;
      logic       rn;
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 5) == 0) lv[k] = ~lv[k];
      if ($urandom_range(0, 2) == 0) lv[4] = ~lv[4];
      ws = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      rn = ($urandom_range(0, 199) != 0);
      tick(lv[0], lv[1], lv[2], lv[3], lv[4], ws, rn);
    end
    idle(4);
    $display("txn random done moves=%0d over=%0d", m_moves, m_over);
    chk("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
